// File: rtl/tft_seq_pkg.sv
// Shared definitions for the TFT power sequencer: state encodings, state width,
// default cycle constants and a small helper for sizing the shared counter.
package tft_seq_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ENC_IDLE     = 3'd0;
    localparam logic [STATE_W-1:0] ENC_RST_LOW  = 3'd1;
    localparam logic [STATE_W-1:0] ENC_RST_WAIT = 3'd2;
    localparam logic [STATE_W-1:0] ENC_INIT     = 3'd3;
    localparam logic [STATE_W-1:0] ENC_TIMING   = 3'd4;
    localparam logic [STATE_W-1:0] ENC_BL_ON    = 3'd5;
    localparam logic [STATE_W-1:0] ENC_RUN      = 3'd6;
    localparam logic [STATE_W-1:0] ENC_FAULT    = 3'd7;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = ENC_IDLE,
        ST_RST_LOW  = ENC_RST_LOW,
        ST_RST_WAIT = ENC_RST_WAIT,
        ST_INIT     = ENC_INIT,
        ST_TIMING   = ENC_TIMING,
        ST_BL_ON    = ENC_BL_ON,
        ST_RUN      = ENC_RUN,
        ST_FAULT    = ENC_FAULT
    } seq_state_e;

    // Defaults assume the 9 MHz pixel clock drives the sequencer.
    localparam int DEF_RST_LOW_CYC  = 90;
    localparam int DEF_RST_WAIT_CYC = 1080000;
    localparam int DEF_INIT_TO_CYC  = 450000;
    localparam int DEF_MAX_RETRY    = 3;
    localparam int DEF_BL_STEP_CYC  = 9000;
    localparam int DEF_PWM_BITS     = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/tft_bl_pwm.sv
// Backlight duty ramp and PWM compare for the TFT power sequencer.
// Only compiled when TFT_BL_PWM_EN is defined.
// Duty is cleared while clr is high and steps by one on each step pulse until it
// saturates at full scale. pwm_on_next is the PWM level that goes with the counter
// and duty values being loaded this cycle, so the parent can register it in step
// with its own state register.
`ifdef TFT_BL_PWM_EN
module tft_bl_pwm #(
    parameter int PWM_BITS = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic step,
    output logic duty_full,
    output logic pwm_on_next
);

    logic [PWM_BITS-1:0] duty_q;
    logic [PWM_BITS-1:0] duty_d;
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [PWM_BITS-1:0] pwm_cnt_d;

    // Next duty and free-running PWM counter values.
    always_comb begin
        duty_d    = duty_q;
        pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
        if (clr) begin
            duty_d = '0;
        end else if (step && (duty_q != '1)) begin
            duty_d = duty_q + PWM_BITS'(1);
        end
    end

    assign duty_full   = (duty_q == '1);
    assign pwm_on_next = (pwm_cnt_d < duty_d);

    // Duty and PWM counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_q    <= '0;
            pwm_cnt_q <= '0;
        end else begin
            duty_q    <= duty_d;
            pwm_cnt_q <= pwm_cnt_d;
        end
    end

endmodule
`endif

// File: rtl/tft_power_sequencer.sv
// TFT panel power-up / power-down sequencer.
// Pulses the panel hard reset, launches the SPI initialiser (with retries), releases
// the timing generator, brings up the backlight and reports ready / error.
// Optional macro TFT_BL_PWM_EN: ramp the backlight through a PWM duty sweep in BL_ON
// instead of switching it straight on.
// Every output is registered and decoded from the next state, so the outputs always
// describe the state the sequencer is in during the same cycle.
module tft_power_sequencer
    import tft_seq_pkg::*;
#(
    parameter int RST_LOW_CYC  = DEF_RST_LOW_CYC,
    parameter int RST_WAIT_CYC = DEF_RST_WAIT_CYC,
    parameter int INIT_TO_CYC  = DEF_INIT_TO_CYC,
    parameter int MAX_RETRY    = DEF_MAX_RETRY,
    parameter int BL_STEP_CYC  = DEF_BL_STEP_CYC,
    parameter int PWM_BITS     = DEF_PWM_BITS
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               en,
    input  logic               init_done,
    input  logic               vsync,
    output logic               lcd_rst_n,
    output logic               spi_start,
    output logic               timing_rst_n,
    output logic               tft_bl,
    output logic               ready,
    output logic               error,
    output logic [STATE_W-1:0] state_o
);

    localparam int CNT_MAX_VAL = max3(RST_WAIT_CYC, INIT_TO_CYC, BL_STEP_CYC);
    localparam int CNT_W       = $clog2(CNT_MAX_VAL + 1);
    localparam int RETRY_W     = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    // Counter values seen in the final cycle of each timed state.
    localparam logic [CNT_W-1:0]   RST_LOW_LAST  = CNT_W'(RST_LOW_CYC - 1);
    localparam logic [CNT_W-1:0]   RST_WAIT_LAST = CNT_W'(RST_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0]   INIT_TO_LAST  = CNT_W'(INIT_TO_CYC - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIM     = RETRY_W'(MAX_RETRY);

    seq_state_e         state_q;
    seq_state_e         state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [RETRY_W-1:0] retry_q;
    logic [RETRY_W-1:0] retry_d;
    logic               init_done_prev_q;
    logic               vsync_prev_q;
    logic               init_rise;
    logic               vsync_rise;

    logic lcd_rst_n_q,    lcd_rst_n_d;
    logic spi_start_q,    spi_start_d;
    logic timing_rst_n_q, timing_rst_n_d;
    logic tft_bl_q,       tft_bl_d;
    logic ready_q,        ready_d;
    logic error_q,        error_d;

    // The previous-cycle registers track the inputs in every state, so a level that
    // is already high when INIT/TIMING is entered never looks like an edge.
    assign init_rise  = init_done & ~init_done_prev_q;
    assign vsync_rise = vsync & ~vsync_prev_q;

`ifdef TFT_BL_PWM_EN
    localparam logic [CNT_W-1:0] BL_STEP_LAST = CNT_W'(BL_STEP_CYC - 1);

    logic bl_step;
    logic duty_full;
    logic pwm_on_next;
    logic pwm_clr;
    logic pwm_step;

    // One duty step per BL_STEP_CYC cycles; the last step at full duty ends BL_ON.
    assign bl_step  = (state_q == ST_BL_ON) && (cnt_q == BL_STEP_LAST);
    assign pwm_clr  = !(state_d inside {ST_BL_ON, ST_RUN});
    assign pwm_step = bl_step && !duty_full;

    tft_bl_pwm #(
        .PWM_BITS (PWM_BITS)
    ) u_bl_pwm (
        .clk         (sys_clk),
        .rst         (sys_rst),
        .clr         (pwm_clr),
        .step        (pwm_step),
        .duty_full   (duty_full),
        .pwm_on_next (pwm_on_next)
    );
`else
    logic unused_cfg;
    assign unused_cfg = ^PWM_BITS;
`endif

    // Next-state, retry and counter logic; an en drop overrides every other transition.
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        case (state_q)
            ST_IDLE: begin
                retry_d = '0;
                if (en) state_d = ST_RST_LOW;
            end
            ST_RST_LOW: begin
                if (cnt_q == RST_LOW_LAST) state_d = ST_RST_WAIT;
            end
            ST_RST_WAIT: begin
                if (cnt_q == RST_WAIT_LAST) state_d = ST_INIT;
            end
            ST_INIT: begin
                if (init_rise) begin
                    state_d = ST_TIMING;
                end else if (cnt_q == INIT_TO_LAST) begin
                    if (retry_q < RETRY_LIM) begin
                        retry_d = retry_q + RETRY_W'(1);
                        state_d = ST_RST_LOW;
                    end else begin
                        state_d = ST_FAULT;
                    end
                end
            end
            ST_TIMING: begin
                if (vsync_rise) begin
                    state_d = ST_BL_ON;
                end else if (cnt_q == INIT_TO_LAST) begin
                    state_d = ST_FAULT;
                end
            end
            ST_BL_ON: begin
`ifdef TFT_BL_PWM_EN
                if (bl_step && duty_full) state_d = ST_RUN;
`else
                state_d = ST_RUN;
`endif
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            ST_FAULT: begin
                if (!en) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (!en && (state_q != ST_IDLE) && (state_q != ST_FAULT)) begin
            state_d = ST_IDLE;
        end

        // Shared cycle counter: restarts on any state change, saturates otherwise.
        if (state_d != state_q) begin
            cnt_d = '0;
`ifdef TFT_BL_PWM_EN
        end else if (bl_step) begin
            cnt_d = '0;
`endif
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Output decode from the state being entered, registered below.
    always_comb begin
        lcd_rst_n_d    = state_d inside {ST_RST_WAIT, ST_INIT, ST_TIMING, ST_BL_ON, ST_RUN};
        spi_start_d    = (state_d == ST_INIT) && (state_q != ST_INIT);
        timing_rst_n_d = state_d inside {ST_TIMING, ST_BL_ON, ST_RUN};
        ready_d        = (state_d == ST_RUN);
        error_d        = (state_d == ST_FAULT);
`ifdef TFT_BL_PWM_EN
        tft_bl_d       = (state_d == ST_RUN) || ((state_d == ST_BL_ON) && pwm_on_next);
`else
        tft_bl_d       = state_d inside {ST_BL_ON, ST_RUN};
`endif
    end

    // Single register stage for the FSM, counters, edge history and outputs.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q          <= ST_IDLE;
            cnt_q            <= '0;
            retry_q          <= '0;
            init_done_prev_q <= 1'b0;
            vsync_prev_q     <= 1'b0;
            lcd_rst_n_q      <= 1'b0;
            spi_start_q      <= 1'b0;
            timing_rst_n_q   <= 1'b0;
            tft_bl_q         <= 1'b0;
            ready_q          <= 1'b0;
            error_q          <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            retry_q          <= retry_d;
            init_done_prev_q <= init_done;
            vsync_prev_q     <= vsync;
            lcd_rst_n_q      <= lcd_rst_n_d;
            spi_start_q      <= spi_start_d;
            timing_rst_n_q   <= timing_rst_n_d;
            tft_bl_q         <= tft_bl_d;
            ready_q          <= ready_d;
            error_q          <= error_d;
        end
    end

    assign lcd_rst_n    = lcd_rst_n_q;
    assign spi_start    = spi_start_q;
    assign timing_rst_n = timing_rst_n_q;
    assign tft_bl       = tft_bl_q;
    assign ready        = ready_q;
    assign error        = error_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_tft_power_sequencer.sv
// Self-checking bench for tft_power_sequencer: directed scenarios plus randomized
// en / init_done / vsync / reset activity, compared every cycle against a
// duration-based reference model of the power sequence.
module tb_tft_power_sequencer;

    localparam int RST_LOW_CYC  = 4;
    localparam int RST_WAIT_CYC = 8;
    localparam int INIT_TO_CYC  = 20;
    localparam int MAX_RETRY    = 2;
    localparam int BL_STEP_CYC  = 2;
    localparam int PWM_BITS     = 4;
`ifdef TFT_BL_PWM_EN
    localparam bit PWM_ON = 1'b1;
`else
    localparam bit PWM_ON = 1'b0;
`endif
    localparam int BL_ON_CYC = PWM_ON ? (2 ** PWM_BITS) * BL_STEP_CYC : 1;

    // Phase codes as published for state_o.
    localparam int P_IDLE = 0, P_RST_LOW = 1, P_RST_WAIT = 2, P_INIT = 3;
    localparam int P_TIMING = 4, P_BL_ON = 5, P_RUN = 6, P_FAULT = 7;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       en = 1'b0;
    logic       init_done = 1'b0;
    logic       vsync = 1'b0;
    logic       lcd_rst_n, spi_start, timing_rst_n, tft_bl, ready, error;
    logic [2:0] state_o;

    int n_checks = 0;
    int n_fail   = 0;

    tft_power_sequencer #(
        .RST_LOW_CYC  (RST_LOW_CYC),
        .RST_WAIT_CYC (RST_WAIT_CYC),
        .INIT_TO_CYC  (INIT_TO_CYC),
        .MAX_RETRY    (MAX_RETRY),
        .BL_STEP_CYC  (BL_STEP_CYC),
        .PWM_BITS     (PWM_BITS)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .en           (en),
        .init_done    (init_done),
        .vsync        (vsync),
        .lcd_rst_n    (lcd_rst_n),
        .spi_start    (spi_start),
        .timing_rst_n (timing_rst_n),
        .tft_bl       (tft_bl),
        .ready        (ready),
        .error        (error),
        .state_o      (state_o)
    );

    always #5 sys_clk = ~sys_clk;

    // ---------------- reference model ----------------
    int m_phase = P_IDLE;  // current phase code
    int m_age = 0;         // cycles already spent in the phase (0 on entry)
    int m_retries = 0;
    int m_pwm = 0;         // cycles since reset, modulo PWM period
    bit m_spi = 0;
    bit m_pd = 0, m_pv = 0;

    task automatic model_step(input bit r, input bit e, input bit d, input bit v);
        int nxt;
        int done;
        bit d_rise, v_rise;
        if (r) begin
            m_phase = P_IDLE; m_age = 0; m_retries = 0; m_pwm = 0;
            m_spi = 0; m_pd = 0; m_pv = 0;
            return;
        end
        d_rise = d && !m_pd;
        v_rise = v && !m_pv;
        m_pd   = d;
        m_pv   = v;
        m_pwm  = (m_pwm + 1) % (2 ** PWM_BITS);
        done   = m_age + 1;
        nxt    = m_phase;
        case (m_phase)
            P_IDLE:     begin m_retries = 0; if (e) nxt = P_RST_LOW; end
            P_RST_LOW:  if (done == RST_LOW_CYC) nxt = P_RST_WAIT;
            P_RST_WAIT: if (done == RST_WAIT_CYC) nxt = P_INIT;
            P_INIT: begin
                if (d_rise) nxt = P_TIMING;
                else if (done == INIT_TO_CYC) begin
                    if (m_retries < MAX_RETRY) begin m_retries++; nxt = P_RST_LOW; end
                    else nxt = P_FAULT;
                end
            end
            P_TIMING: begin
                if (v_rise) nxt = P_BL_ON;
                else if (done == INIT_TO_CYC) nxt = P_FAULT;
            end
            P_BL_ON:  if (done == BL_ON_CYC) nxt = P_RUN;
            P_FAULT:  if (!e) nxt = P_IDLE;
            default: ;
        endcase
        if (!e && m_phase != P_IDLE && m_phase != P_FAULT) nxt = P_IDLE;
        m_spi   = (nxt == P_INIT) && (m_phase != P_INIT);
        m_age   = (nxt == m_phase) ? m_age + 1 : 0;
        m_phase = nxt;
    endtask

    function automatic logic [8:0] expected_outputs();
        logic lcd, tim, bl;
        lcd = (m_phase >= P_RST_WAIT) && (m_phase <= P_RUN);
        tim = (m_phase >= P_TIMING) && (m_phase <= P_RUN);
        if (m_phase == P_RUN)        bl = 1'b1;
        else if (m_phase == P_BL_ON) bl = PWM_ON ? (m_pwm < (m_age / BL_STEP_CYC)) : 1'b1;
        else                         bl = 1'b0;
        return {lcd, m_spi, tim, bl, (m_phase == P_RUN), (m_phase == P_FAULT), 3'(m_phase)};
    endfunction

    // ---------------- per-cycle compare and event trackers ----------------
    int spi_pulses = 0;
    int low_run = 0;
    int low_runs[$];
    int bl_run = 0;
    int last_bl_run = -1;
    logic [8:0] exp_vec, got_vec;
    bit s_rst, s_en, s_done, s_vs;

    always @(posedge sys_clk) begin
        s_rst = sys_rst; s_en = en; s_done = init_done; s_vs = vsync;
        model_step(s_rst, s_en, s_done, s_vs);
        #1;
        exp_vec = expected_outputs();
        got_vec = {lcd_rst_n, spi_start, timing_rst_n, tft_bl, ready, error, state_o};
        n_checks++;
        if (got_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL cycle_model t=%0t: got lcd_rst_n=%b spi=%b trst_n=%b bl=%b rdy=%b err=%b st=%0d, required lcd_rst_n=%b spi=%b trst_n=%b bl=%b rdy=%b err=%b st=%0d",
                     $time, got_vec[8], got_vec[7], got_vec[6], got_vec[5], got_vec[4], got_vec[3], got_vec[2:0],
                     exp_vec[8], exp_vec[7], exp_vec[6], exp_vec[5], exp_vec[4], exp_vec[3], exp_vec[2:0]);
        end
        if (spi_start === 1'b1) spi_pulses++;
        if (sys_rst || !en) low_run = 0;
        else if (lcd_rst_n === 1'b0) low_run++;
        else if (low_run > 0) begin low_runs.push_back(low_run); low_run = 0; end
        if (state_o == 3'd5) bl_run++;
        else if (bl_run > 0) begin last_bl_run = bl_run; bl_run = 0; end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input int actual, input int required);
        n_checks++;
        if (actual != required) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, actual, required);
        end
        else $display("check %s: %0d ok", name, actual);
    endtask

    task automatic wait_state(input int code, input int budget, input string name);
        bit hit = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge sys_clk);
            if (state_o == 3'(code)) begin hit = 1; break; end
        end
        n_checks++;
        if (!hit) begin
            n_fail++;
            $display("FAIL %s: state_o=%0d after %0d cycles, required %0d", name, state_o, budget, code);
        end
    endtask

    task automatic go_idle();
        @(negedge sys_clk);
        en = 0; init_done = 0; vsync = 0;
        repeat (2) @(negedge sys_clk);
        spi_pulses = 0; low_runs.delete(); last_bl_run = -1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int bad;
        repeat (3) @(negedge sys_clk);
        chk("reset_outputs", int'({lcd_rst_n, spi_start, timing_rst_n, tft_bl, ready, error, state_o}), 0);
        sys_rst = 0;
        go_idle();

        // Happy path
        en = 1;
        wait_state(P_INIT, 40, "happy_reach_init");
        chk("happy_spi_first_init_cycle", spi_start, 1);
        repeat (5) @(negedge sys_clk);
        init_done = 1;
        repeat (3) @(negedge sys_clk);
        vsync = 1;
        repeat (2) @(negedge sys_clk);
        vsync = 0;
        wait_state(P_RUN, BL_ON_CYC + 10, "happy_reach_run");
        chk("happy_ready", ready, 1);
        chk("happy_timing_rst_n", timing_rst_n, 1);
        chk("happy_tft_bl", tft_bl, 1);
        chk("happy_spi_pulses", spi_pulses, 1);
        chk("happy_low_run_count", low_runs.size(), 1);
        if (low_runs.size() > 0) chk("happy_low_run_len", low_runs[0], RST_LOW_CYC);
        chk("happy_bl_on_cycles", last_bl_run, BL_ON_CYC);

        // Retry exhaustion into FAULT
        go_idle();
        en = 1;
        wait_state(P_FAULT, 3 * (RST_LOW_CYC + RST_WAIT_CYC + INIT_TO_CYC) + 10, "retry_reach_fault");
        chk("retry_spi_pulses", spi_pulses, MAX_RETRY + 1);
        chk("retry_low_run_count", low_runs.size(), MAX_RETRY + 1);
        bad = 0;
        foreach (low_runs[i]) if (low_runs[i] != RST_LOW_CYC) bad++;
        chk("retry_low_run_lens_bad", bad, 0);
        chk("retry_error", error, 1);
        repeat (5) @(negedge sys_clk);
        chk("fault_held_with_en", state_o, P_FAULT);
        en = 0;
        @(negedge sys_clk);
        chk("fault_exit_state", state_o, P_IDLE);
        chk("fault_exit_error", error, 0);

        // Stale init_done
        go_idle();
        init_done = 1;
        @(negedge sys_clk);
        en = 1;
        wait_state(P_INIT, 40, "stale_reach_init");
        repeat (6) @(negedge sys_clk);
        chk("stale_done_ignored", state_o, P_INIT);
        init_done = 0;
        @(negedge sys_clk);
        init_done = 1;
        @(negedge sys_clk);
        chk("stale_reraise_timing", state_o, P_TIMING);

        // Abort in the same cycle init_done rises
        go_idle();
        en = 1;
        wait_state(P_INIT, 40, "abort_reach_init");
        repeat (2) @(negedge sys_clk);
        init_done = 1;
        en = 0;
        @(negedge sys_clk);
        chk("abort_state", state_o, P_IDLE);
        chk("abort_lcd_rst_n", lcd_rst_n, 0);
        chk("abort_ready", ready, 0);

        // Asynchronous reset during RST_WAIT
        go_idle();
        en = 1;
        wait_state(P_RST_WAIT, 20, "rstpulse_reach_wait");
        repeat (2) @(negedge sys_clk);
        sys_rst = 1;
        #1;
        chk("rstpulse_outputs", int'({lcd_rst_n, spi_start, timing_rst_n, tft_bl, ready, error, state_o}), 0);
        @(negedge sys_clk);
        sys_rst = 0;
        @(negedge sys_clk);
        chk("rstpulse_restart", state_o, P_RST_LOW);

        // Randomized activity, checked by the per-cycle model
        for (int c = 0; c < 3000; c++) begin
            @(negedge sys_clk);
            sys_rst = ($urandom_range(999) < 2);
            if (en) begin
                if ($urandom_range(99) < 1) en = 0;
            end else if ($urandom_range(99) < 30) en = 1;
            if ($urandom_range(99) < 12) init_done = ~init_done;
            if ($urandom_range(99) < 20) vsync = ~vsync;
        end
        @(negedge sys_clk);
        sys_rst = 0;
        repeat (3) @(negedge sys_clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
